// File: rtl/fib_seq_engine.sv
// rtl/fib_seq_engine.sv - Fibonacci-style sequence engine over a register file; optional FIB_SATURATE_EN saturates overflowing terms
module fib_seq_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    input  logic [ADDR_W-1:0] count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [2:0]        fsmState,
    output logic [DATA_W-1:0] currentResult
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD0 = 3'd1,
        S_LOAD1 = 3'd2,
        S_CALC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] seed0_q, seed1_q;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] k_q;
    logic [DATA_W:0]   sum_q;
    logic              ovf_q;
    logic [DATA_W-1:0] rd_q;

    logic              last_term;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] term;
    logic [ADDR_W-1:0] idx_a, idx_b;

    // Operand indices for the term being computed: R[k-2] and R[k-1]
    assign idx_a = k_q - ADDR_W'(2);
    assign idx_b = k_q - ADDR_W'(1);

    // Last term is R[N-1]; k never exceeds N-1 while writing
    assign last_term = ({1'b0, k_q} == (n_q - (ADDR_W + 1)'(1)));

`ifdef FIB_SATURATE_EN
    assign term = sum_q[DATA_W] ? {DATA_W{1'b1}} : sum_q[DATA_W-1:0];
`else
    assign term = sum_q[DATA_W-1:0];
`endif

    // Term-count decode: 0 selects the whole file, 1 is promoted to 2
    always_comb begin
        n_d = {1'b0, count};
        if (count == '0) begin
            n_d = (ADDR_W + 1)'(DEPTH);
        end else if (count == ADDR_W'(1)) begin
            n_d = (ADDR_W + 1)'(2);
        end
    end

    // Next-state logic; unused codes fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD0;
            S_LOAD0: state_d = S_LOAD1;
            S_LOAD1: state_d = (n_q == (ADDR_W + 1)'(2)) ? S_DONE : S_CALC;
            S_CALC:  state_d = S_WRITE;
            S_WRITE: state_d = last_term ? S_DONE : S_CALC;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single register-file write port shared by seed loads and term writes
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = k_q;
        wr_data = term;
        case (state_q)
            S_LOAD0: begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = seed0_q;
            end
            S_LOAD1: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_W'(1);
                wr_data = seed1_q;
            end
            S_WRITE: wr_en = 1'b1;
            default: ;
        endcase
    end

    // Control state: FSM, run parameters captured at start, sum and overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            seed0_q <= '0;
            seed1_q <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                seed0_q <= seed0;
                seed1_q <= seed1;
                n_q     <= n_d;
                k_q     <= ADDR_W'(2);
                ovf_q   <= 1'b0;
            end
            if (state_q == S_CALC) begin
                sum_q <= {1'b0, regs_q[idx_a]} + {1'b0, regs_q[idx_b]};
            end
            if (state_q == S_WRITE) begin
                k_q <= k_q + ADDR_W'(1);
                if (sum_q[DATA_W]) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // Register file and registered read port with write-through bypass
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
            end
            rd_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : regs_q[rd_addr];
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign ovf           = ovf_q;
    assign fsmState      = state_q;
    assign currentResult = rd_q;

endmodule

// File: tb/tb_fib_seq_engine.sv
// tb/tb_fib_seq_engine.sv - randomized model-checked bench for fib_seq_engine
module tb_fib_seq_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed0 = '0;
    logic [15:0] seed1 = '0;
    logic [3:0]  count = '0;
    logic [3:0]  rd_addr = '0;
    logic        busy, done, ovf;
    logic [2:0]  fsmState;
    logic [15:0] currentResult;

    int n_checks = 0;
    int n_fail = 0;

    fib_seq_engine #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .seed0(seed0), .seed1(seed1),
        .count(count), .rd_addr(rd_addr), .busy(busy), .done(done), .ovf(ovf),
        .fsmState(fsmState), .currentResult(currentResult)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is a timeline of edges t since the start edge
    int unsigned m_r [16];
    bit          m_valid = 0;
    bit          m_active = 0;
    int          m_t = 0;
    int          m_n = 2;
    int unsigned m_s0 = 0, m_s1 = 0;
    bit          m_ovf = 0;
    int          m_state = 0;
    int unsigned m_cr = 0;

    task automatic model_step();
        int k;
        int unsigned sum;
        if (reset) begin
            foreach (m_r[i]) m_r[i] = 0;
            m_active = 0;
            m_ovf = 0;
            m_cr = 0;
            m_state = 0;
            m_valid = 1;
        end else begin
            if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_t = 0;
                    m_s0 = seed0;
                    m_s1 = seed1;
                    m_n = (count == 0) ? 16 : (count == 1) ? 2 : int'(count);
                    m_ovf = 0;
                end
            end else begin
                m_t++;
                if (m_t == 1) m_r[0] = m_s0;
                else if (m_t == 2) m_r[1] = m_s1;
                else if (m_t % 2 == 0 && m_t <= 2 * m_n - 2) begin
                    k = m_t / 2;
                    sum = m_r[k-2] + m_r[k-1];
                    if (sum > 65535) begin
                        m_ovf = 1;
`ifdef FIB_SATURATE_EN
                        sum = 65535;
`else
                        sum = sum - 65536;
`endif
                    end
                    m_r[k] = sum;
                end
                if (m_t == 2 * m_n - 1) m_active = 0;
            end
            if (!m_active) m_state = 0;
            else if (m_t == 0) m_state = 1;
            else if (m_t == 1) m_state = 2;
            else if (m_t == 2 * m_n - 2) m_state = 5;
            else m_state = (m_t % 2 == 0) ? 3 : 4;
            m_cr = m_r[rd_addr];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("busy", 32'(busy), 32'(m_state != 0));
            check("done", 32'(done), 32'(m_state == 5));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("fsmState", 32'(fsmState), 32'(m_state));
            check("currentResult", 32'(currentResult), m_cr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic run(input logic [15:0] s0, input logic [15:0] s1, input logic [3:0] c, output int edges);
        bit got;
        seed0 = s0; seed1 = s1; count = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            edges++;
            if (done) got = 1;
        end
        if (!got) check("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic read_reg(input int a, output logic [15:0] v);
        rd_addr = 4'(a);
        @(negedge clk);
        v = currentResult;
    endtask

    int unsigned fib [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
    int unsigned r29 [6] = '{2, 1, 3, 4, 7, 11};

    initial begin
        int edges;
        int dcount;
        logic [15:0] v;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(fsmState), 0);
        check("rst_result", 32'(currentResult), 0);
        check("rst_ovf", 32'(ovf), 0);
        reset = 1'b0;
        @(negedge clk);

        run(16'd0, 16'd1, 4'd0, edges);
        check("lat_n16", 32'(edges), 30);
        for (int i = 0; i < 16; i++) begin
            read_reg(i, v);
            check("fib_reg", 32'(v), fib[i]);
        end

        run(16'd2, 16'd1, 4'd6, edges);
        check("lat_n6", 32'(edges), 10);
        for (int i = 0; i < 16; i++) begin
            read_reg(i, v);
            check("n6_reg", 32'(v), (i < 6) ? r29[i] : fib[i]);
        end

        run(16'd40000, 16'd30000, 4'd3, edges);
        check("lat_n3", 32'(edges), 4);
        check("ovf_set", 32'(ovf), 1);
        read_reg(2, v);
`ifdef FIB_SATURATE_EN
        check("ovf_term", 32'(v), 65535);
`else
        check("ovf_term", 32'(v), 4464);
`endif
        seed0 = 16'd0; seed1 = 16'd1; count = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ovf_clear", 32'(ovf), 0);
        repeat (4) @(negedge clk);

        rd_addr = 4'd2;
        run(16'd0, 16'd1, 4'd4, edges);
        check("wt_hold", 32'(currentResult), 1);

        seed0 = 16'd5; seed1 = 16'd7; count = 4'd3; start = 1'b1;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        start = 1'b0;
        check("held_start_dones", 32'(dcount), 3);
        repeat (8) @(negedge clk);

        seed0 = 16'd1; seed1 = 16'd1; count = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_state", 32'(fsmState), 0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", 32'(dcount), 0);
        for (int i = 0; i < 16; i++) begin
            read_reg(i, v);
            check("abort_reg", 32'(v), 0);
        end

        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 7) == 0);
            seed0   = 16'($urandom);
            seed1   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
            count   = 4'($urandom);
            rd_addr = 4'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fib_seq_engine.md
FIB_SEQ_ENGINE -- requirements
Module: fib_seq_engine

Interface
REQ-001 Parameter DATA_W, default 16, is the register and result width in bits.
REQ-002 Parameter ADDR_W, default 4, is the register address width; register count DEPTH = 2**ADDR_W.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the reset: synchronous, active-high.
REQ-005 Port start  input  1  requests a sequence run; sampled only in IDLE.
REQ-006 Port seed0  input  DATA_W  is the value written to R0; sampled on the start edge.
REQ-007 Port seed1  input  DATA_W  is the value written to R1; sampled on the start edge.
REQ-008 Port count  input  ADDR_W  is the term count N; sampled on the start edge; 0 means DEPTH; 1 is treated as 2.
REQ-009 Port rd_addr  input  ADDR_W  is the register-file read select.
REQ-010 Port busy  output  1  is high in every state except IDLE.
REQ-011 Port done  output  1  is high only in DONE, for exactly one cycle per run.
REQ-012 Port ovf  output  1  is a sticky overflow flag.
REQ-013 Port fsmState  output  3  is the current state encoding.
REQ-014 Port currentResult  output  DATA_W  is the registered read of R[rd_addr].

Function
REQ-015 The FSM SHALL use these encodings: IDLE=0, LOAD0=1, LOAD1=2, CALC=3, WRITE=4, DONE=5; codes 6-7 return to IDLE on the next edge.
REQ-016 Transitions SHALL be:
- IDLE -> LOAD0 on start=1; start is ignored when busy=1.
- LOAD0 -> LOAD1, writing seed0 to R0.
- LOAD1 -> DONE if N=2, otherwise -> CALC; R1 is written with seed1.
- CALC -> WRITE, latching R[k-2]+R[k-1] into a DATA_W+1 sum register.
- WRITE -> CALC, writing R[k] and incrementing k, or -> DONE after writing R[N-1].
- DONE -> IDLE.
REQ-017 The term index k SHALL start at 2; registers R[N]..R[DEPTH-1] SHALL keep their prior contents.
REQ-018 Latency SHALL be as follows: done is high in the cycle following the 2N-2nd rising edge after the edge that samples start.
REQ-019 Arithmetic: an overflow occurs when bit DATA_W of the sum is 1; each overflow sets ovf.
REQ-020 ovf SHALL clear on the start edge and otherwise hold until reset.
REQ-021 currentResult SHALL equal R[rd_addr] one cycle after rd_addr is presented.
REQ-022 A read of the address being written in the same cycle SHALL return the newly written value (write-through).
REQ-023 A rd_addr change during a run SHALL be legal and SHALL NOT disturb the computation.

Reset
REQ-024 While reset=1 at an edge, the block SHALL set state to IDLE, k=0, all R[i]=0, currentResult=0, ovf=0, done=0, and busy=0.
REQ-025 Reset asserted mid-run SHALL abort the run with no done pulse; a start presented in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 Macro FIB_SATURATE_EN defined: on overflow, the stored term SHALL be all-ones (2**DATA_W-1), and ovf SHALL still set.
REQ-027 Macro FIB_SATURATE_EN undefined: on overflow, the stored term SHALL wrap modulo 2**DATA_W, and ovf SHALL still set.

Verification
REQ-028 Default params, seed0=0, seed1=1, count=0, start pulse -> done exactly 30 edges later; reading rd_addr 0..15 afterwards returns 0,1,1,2,3,5,...,377,610.
REQ-029 Seeds 2,1, count=6 -> done after 10 edges; R0..R5 read 2,1,3,4,7,11; R6..R15 unchanged from the prior run.
REQ-030 DATA_W=16, seeds 40000,30000, count=3 -> R2=4464 without the macro or 65535 with it; ovf=1 in both builds; ovf clears on the next start.
REQ-031 Reset asserted in cycle 5 of a count=16 run -> fsmState=0 next cycle; no done pulse; every rd_addr reads 0.
REQ-032 start held high through an entire run -> start is ignored while busy, and a second run begins the edge after DONE returns to IDLE.
REQ-033 rd_addr=2 held during seeds 0,1 run -> currentResult shows 1 on the edge that writes R2 (write-through), and stays 1.
